uart_fifo_bridge: RTL and testbench
===================================

Name: uart_fifo_bridge

Overview:
- Buffers bytes between the CPU-side bus and the UART core: a TX FIFO drains into the UART transmit handshake, an RX FIFO captures completed UART receive bytes.
- Sits directly upstream/downstream of the UART core: drives its `we`/`en`/`data_in`, consumes its `tx_busy`/`rx_done`/`data_out`.
- Frees software from per-byte polling of `tx_busy`.

Parameters:
- ADDR_W, 4, log2 of each FIFO depth (depth = 16 entries per FIFO).

Ports:
- clk  input  1  system clock, same domain as the UART core
- rst  input  1  synchronous active-low reset (asserted when 0)
- enable  input  1  global enable; passed to UART as uart_en
- tx_wr  input  1  push tx_wdata into TX FIFO this cycle
- tx_wdata  input  8  byte to transmit
- tx_full  output  1  TX FIFO holds 2^ADDR_W entries
- tx_count  output  ADDR_W+1  TX FIFO occupancy
- rx_rd  input  1  pop RX FIFO head this cycle
- rx_rdata  output  8  RX FIFO head (first-word fall-through)
- rx_empty  output  1  RX FIFO has no entries
- rx_count  output  ADDR_W+1  RX FIFO occupancy
- ovf_clr  input  1  clears tx_ovf and rx_ovf
- tx_ovf  output  1  sticky: push attempted while TX FIFO full
- rx_ovf  output  1  sticky: byte received while RX FIFO full
- uart_we  output  1  to UART `we`
- uart_en  output  1  to UART `en`
- uart_din  output  8  to UART `data_in`
- uart_tx_busy  input  1  from UART
- uart_rx_done  input  1  from UART; 1-cycle pulse, uart_dout valid in the same cycle
- uart_dout  input  8  from UART `data_out`

Behaviour:
- Reset (rst=0 at posedge clk):
  - Both FIFOs empty: pointers and counts 0, tx_full=0, rx_empty=1.
  - tx_ovf=0, rx_ovf=0, uart_we=0, uart_din=0, rx_rdata=0.
  - Drain FSM to T_IDLE.
  - Reset mid-transfer discards all buffered bytes; the UART may still finish a byte already in flight.
- uart_en = enable (combinational).
- TX FIFO push:
  - tx_wr & !tx_full writes at the write pointer and increments the pointer and count next cycle.
  - tx_wr & tx_full drops the byte and sets tx_ovf.
  - Pointers wrap modulo 2^ADDR_W.
- Drain FSM (registered outputs):
  - T_IDLE:
    - If the TX FIFO is non-empty, !uart_tx_busy and enable: load uart_din <= TX head, set uart_we <= 1, go to T_LOAD.
  - T_LOAD:
    - Hold uart_we=1 and uart_din stable. The UART only samples on its oversample tick, so the hold lasts many cycles.
    - When uart_tx_busy=1: pop the TX head (read pointer +1, count -1), set uart_we <= 0, go to T_BUSY.
    - If enable drops: set uart_we <= 0, go to T_IDLE with no pop.
  - T_BUSY:
    - Wait for uart_tx_busy=0, then go to T_IDLE.
    - This is the earliest a next byte may start, giving at least one idle cycle between bytes.
- Simultaneous TX push and pop: count unchanged, both pointers advance. A push is legal when full only if a pop happens the same cycle? No: tx_full is evaluated on current state, so the push is dropped.
- RX FIFO:
  - On uart_rx_done=1 with count < depth: write uart_dout, increment the write pointer.
  - On uart_rx_done=1 when full: byte dropped, rx_ovf set.
  - rx_rdata always shows the head entry (0 when empty).
  - rx_rd & !rx_empty pops. rx_rd when empty is ignored, with no flag.
  - Simultaneous rx_done and rx_rd when full: pop succeeds; the incoming byte is dropped and rx_ovf set (full evaluated pre-pop).
- Overflow flags:
  - ovf_clr has priority over a same-cycle set, so the flag ends at 0.
  - Flags stay set until ovf_clr or reset.
- Counts: ADDR_W+1 bits, range 0..2^ADDR_W, with no wrap on the count itself.

Test Plan:
- Reset with rst=0 for 2 cycles -> tx_count=0, rx_count=0, rx_empty=1, uart_we=0, tx_ovf=rx_ovf=0.
- Push 0x55, 0xA3 with enable=1; model the UART raising busy 40 cycles after we and dropping it 1000 cycles later -> uart_din=0x55 held with uart_we=1 until busy, tx_count 2→1; then 0xA3 presented only after busy falls; tx_count ends 0.
- Push 17 bytes with the UART held busy -> tx_full=1 after 16, 17th dropped, tx_ovf=1, tx_count=16; pulse ovf_clr -> tx_ovf=0.
- Pulse uart_rx_done with uart_dout=0x41, then 0x42 -> rx_count=2, rx_rdata=0x41; rx_rd -> rx_rdata=0x42; rx_rd -> rx_empty=1, rx_rdata=0.
- Fill RX to 16, then uart_rx_done together with rx_rd -> rx_count=15, rx_ovf=1, new byte absent.
- Assert rst=0 while in T_LOAD with 3 bytes queued -> next cycle uart_we=0, tx_count=0, FSM idle; the late uart_tx_busy pulse causes no pop and no count underflow.

Source files
------------

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
//
// Byte buffer between the CPU-side bus and a UART core. Software pushes bytes
// into a TX FIFO; a small drain FSM presents them one at a time to the UART
// transmit handshake (we/data_in, acknowledged by tx_busy). Bytes completed by
// the UART receiver (rx_done/data_out) are captured into an RX FIFO that
// software reads with first-word fall-through semantics.
//
// Ports
//   clk           system clock, shared with the UART core
//   rst           synchronous reset, active low
//   enable        global enable, forwarded to the UART as uart_en
//   tx_wr         push tx_wdata into the TX FIFO this cycle
//   tx_wdata      byte to transmit
//   tx_full       TX FIFO holds 2^ADDR_W entries
//   tx_count      TX FIFO occupancy (0..2^ADDR_W)
//   rx_rd         pop the RX FIFO head this cycle
//   rx_rdata      RX FIFO head, 0 when empty
//   rx_empty      RX FIFO has no entries
//   rx_count      RX FIFO occupancy (0..2^ADDR_W)
//   ovf_clr       clears both sticky overflow flags
//   tx_ovf        sticky: push attempted while the TX FIFO was full
//   rx_ovf        sticky: byte received while the RX FIFO was full
//   uart_we       UART write strobe, held until the UART reports busy
//   uart_en       UART enable (same as enable)
//   uart_din      byte presented to the UART
//   uart_tx_busy  UART transmitter busy
//   uart_rx_done  one-cycle pulse, uart_dout valid in the same cycle
//   uart_dout     byte received by the UART

module uart_fifo_bridge #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              tx_wr,
  input  logic [7:0]        tx_wdata,
  output logic              tx_full,
  output logic [ADDR_W:0]   tx_count,
  input  logic              rx_rd,
  output logic [7:0]        rx_rdata,
  output logic              rx_empty,
  output logic [ADDR_W:0]   rx_count,
  input  logic              ovf_clr,
  output logic              tx_ovf,
  output logic              rx_ovf,
  output logic              uart_we,
  output logic              uart_en,
  output logic [7:0]        uart_din,
  input  logic              uart_tx_busy,
  input  logic              uart_rx_done,
  input  logic [7:0]        uart_dout
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  // ---------------------------------------------------------------------------
  // TX FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [7:0]        tx_mem [DEPTH];
  logic [ADDR_W-1:0] tx_wptr_reg;
  logic [ADDR_W-1:0] tx_rptr_reg;
  logic [ADDR_W:0]   tx_count_reg;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_empty;

  assign tx_full  = (tx_count_reg == DEPTH_CNT);
  assign tx_empty = (tx_count_reg == '0);
  assign tx_count = tx_count_reg;

  // Fullness is judged on the current occupancy, so a push into a full FIFO
  // is dropped even if the drain pops in the same cycle.
  assign tx_push  = tx_wr & ~tx_full;

  always_ff @(posedge clk) begin
    if (rst && tx_push) begin
      tx_mem[tx_wptr_reg] <= tx_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wptr_reg  <= '0;
      tx_rptr_reg  <= '0;
      tx_count_reg <= '0;
    end else begin
      if (tx_push) begin
        tx_wptr_reg <= tx_wptr_reg + PTR_ONE;
      end
      if (tx_pop) begin
        tx_rptr_reg <= tx_rptr_reg + PTR_ONE;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + CNT_ONE;
        2'b01:   tx_count_reg <= tx_count_reg - CNT_ONE;
        default: tx_count_reg <= tx_count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX drain FSM
  //   T_IDLE : wait for a queued byte, an idle UART and enable
  //   T_LOAD : hold we/data until the UART (on its oversample tick) goes busy
  //   T_BUSY : wait for the UART to finish; returning to T_IDLE first gives
  //            at least one idle cycle between consecutive bytes
  // The head is only popped once the UART has demonstrably taken it.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_LOAD = 2'd1,
    T_BUSY = 2'd2
  } drain_state_e;

  drain_state_e state_reg;
  drain_state_e state_next;
  logic         uart_we_reg;
  logic         uart_we_next;
  logic [7:0]   uart_din_reg;
  logic [7:0]   uart_din_next;
  logic         tx_start;

  assign tx_start = ~tx_empty & ~uart_tx_busy & enable;

  // State and registered-output process
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= T_IDLE;
      uart_we_reg  <= 1'b0;
      uart_din_reg <= 8'h00;
    end else begin
      state_reg    <= state_next;
      uart_we_reg  <= uart_we_next;
      uart_din_reg <= uart_din_next;
    end
  end

  // Next-state process
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      T_IDLE: begin
        if (tx_start) begin
          state_next = T_LOAD;
        end
      end
      T_LOAD: begin
        // Busy wins over a same-cycle enable drop: the UART has already
        // taken the byte, so it must be retired from the FIFO.
        if (uart_tx_busy) begin
          state_next = T_BUSY;
        end else if (!enable) begin
          state_next = T_IDLE;
        end
      end
      T_BUSY: begin
        if (!uart_tx_busy) begin
          state_next = T_IDLE;
        end
      end
      default: state_next = T_IDLE;
    endcase
  end

  // Output process: next values of the registered UART outputs and the pop
  always_comb begin
    tx_pop        = 1'b0;
    uart_we_next  = uart_we_reg;
    uart_din_next = uart_din_reg;
    case (state_reg)
      T_IDLE: begin
        if (tx_start) begin
          uart_we_next  = 1'b1;
          uart_din_next = tx_mem[tx_rptr_reg];
        end
      end
      T_LOAD: begin
        if (uart_tx_busy) begin
          tx_pop       = 1'b1;
          uart_we_next = 1'b0;
        end else if (!enable) begin
          uart_we_next = 1'b0;
        end
      end
      T_BUSY: begin
        uart_we_next = 1'b0;
      end
      default: begin
        uart_we_next = 1'b0;
      end
    endcase
  end

  assign uart_we  = uart_we_reg;
  assign uart_din = uart_din_reg;
  assign uart_en  = enable;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        rx_mem [DEPTH];
  logic [ADDR_W-1:0] rx_wptr_reg;
  logic [ADDR_W-1:0] rx_rptr_reg;
  logic [ADDR_W:0]   rx_count_reg;
  logic              rx_full;
  logic              rx_push;
  logic              rx_pop;

  assign rx_full  = (rx_count_reg == DEPTH_CNT);
  assign rx_empty = (rx_count_reg == '0);
  assign rx_count = rx_count_reg;

  // Full is judged before the pop, so a received byte arriving while full is
  // lost even when software reads in the same cycle.
  assign rx_push  = uart_rx_done & ~rx_full;
  assign rx_pop   = rx_rd & ~rx_empty;

  always_ff @(posedge clk) begin
    if (rst && rx_push) begin
      rx_mem[rx_wptr_reg] <= uart_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wptr_reg  <= '0;
      rx_rptr_reg  <= '0;
      rx_count_reg <= '0;
    end else begin
      if (rx_push) begin
        rx_wptr_reg <= rx_wptr_reg + PTR_ONE;
      end
      if (rx_pop) begin
        rx_rptr_reg <= rx_rptr_reg + PTR_ONE;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + CNT_ONE;
        2'b01:   rx_count_reg <= rx_count_reg - CNT_ONE;
        default: rx_count_reg <= rx_count_reg;
      endcase
    end
  end

  // First-word fall-through head; forced to 0 so stale storage never leaks
  // out when the FIFO is empty (including straight after reset).
  assign rx_rdata = rx_empty ? 8'h00 : rx_mem[rx_rptr_reg];

  // ---------------------------------------------------------------------------
  // Sticky overflow flags; a clear beats a same-cycle set
  // ---------------------------------------------------------------------------
  logic tx_ovf_reg;
  logic rx_ovf_reg;
  logic tx_ovf_next;
  logic rx_ovf_next;

  always_comb begin
    tx_ovf_next = tx_ovf_reg | (tx_wr & tx_full);
    rx_ovf_next = rx_ovf_reg | (uart_rx_done & rx_full);
    if (ovf_clr) begin
      tx_ovf_next = 1'b0;
      rx_ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_ovf_reg <= 1'b0;
      rx_ovf_reg <= 1'b0;
    end else begin
      tx_ovf_reg <= tx_ovf_next;
      rx_ovf_reg <= rx_ovf_next;
    end
  end

  assign tx_ovf = tx_ovf_reg;
  assign rx_ovf = rx_ovf_reg;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge. A queue-based reference model
// tracks both FIFOs and the overflow flags; a behavioural UART model reacts to
// uart_we by raising tx_busy after a programmable delay.
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       tx_wr;
  logic [7:0] tx_wdata;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       rx_rd;
  logic [7:0] rx_rdata;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       ovf_clr;
  logic       tx_ovf;
  logic       rx_ovf;
  logic       uart_we;
  logic       uart_en;
  logic [7:0] uart_din;
  logic       uart_tx_busy;
  logic       uart_rx_done;
  logic [7:0] uart_dout;

  always #5 clk = ~clk;

  uart_fifo_bridge #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_count(tx_count),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_count(rx_count),
    .ovf_clr(ovf_clr), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf),
    .uart_we(uart_we), .uart_en(uart_en), .uart_din(uart_din),
    .uart_tx_busy(uart_tx_busy), .uart_rx_done(uart_rx_done), .uart_dout(uart_dout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit m_tx_ovf, m_rx_ovf;

  // UART model state
  bit pop_pending;
  bit force_busy;
  int wait_cnt, busy_left, busy_delay, busy_len;
  bit we_prev, busy_last, en_last, rst_last;

  // Apply the effect of the coming clock edge to the reference model.
  task automatic model_edge();
    bit txf, rxf, rxe;
    busy_last = uart_tx_busy;
    en_last   = enable;
    rst_last  = rst;
    if (!rst) begin
      tx_q.delete();
      rx_q.delete();
      m_tx_ovf = 0;
      m_rx_ovf = 0;
      pop_pending = 0;
      return;
    end
    txf = (tx_q.size() == 16);
    rxf = (rx_q.size() == 16);
    rxe = (rx_q.size() == 0);
    if (tx_wr) begin
      if (txf) m_tx_ovf = 1;
      else tx_q.push_back(tx_wdata);
    end
    if (pop_pending && tx_q.size() != 0) void'(tx_q.pop_front());
    pop_pending = 0;
    if (uart_rx_done) begin
      if (rxf) m_rx_ovf = 1;
      else rx_q.push_back(uart_dout);
    end
    if (rx_rd && !rxe) void'(rx_q.pop_front());
    if (ovf_clr) begin
      m_tx_ovf = 0;
      m_rx_ovf = 0;
    end
  endtask

  task automatic compare_all();
    check("tx_count", tx_count, tx_q.size());
    check("tx_full", tx_full, tx_q.size() == 16);
    check("rx_count", rx_count, rx_q.size());
    check("rx_empty", rx_empty, rx_q.size() == 0);
    check("rx_rdata", rx_rdata, (rx_q.size() != 0) ? rx_q[0] : 8'h00);
    check("tx_ovf", tx_ovf, m_tx_ovf);
    check("rx_ovf", rx_ovf, m_rx_ovf);
    check("uart_en", uart_en, enable);
  endtask

  task automatic handshake_checks();
    if (!rst_last) begin
      check("we_after_rst", uart_we, 0);
      check("din_after_rst", uart_din, 0);
    end
    if (busy_last) check("we_low_when_busy", uart_we, 0);
    if (uart_we && !we_prev) begin
      check("we_start_busy_low", busy_last, 0);
      check("we_start_enabled", en_last, 1);
      check("we_start_nonempty", tx_q.size() != 0, 1);
      if (tx_q.size() != 0) check("we_start_din", uart_din, tx_q[0]);
    end
    we_prev = uart_we;
  endtask

  // UART transmitter: takes the presented byte busy_delay cycles after we.
  task automatic uart_model();
    pop_pending = 0;
    if (force_busy) begin
      uart_tx_busy = 1;
      wait_cnt = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      uart_tx_busy = (busy_left != 0);
    end else begin
      uart_tx_busy = 0;
      if (uart_we) begin
        wait_cnt++;
        if (wait_cnt >= busy_delay) begin
          check("capture_nonempty", tx_q.size() != 0, 1);
          if (tx_q.size() != 0) check("din_at_capture", uart_din, tx_q[0]);
          uart_tx_busy = 1;
          busy_left = busy_len;
          pop_pending = rst;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    tx_wr = 0;
    rx_rd = 0;
    uart_rx_done = 0;
    ovf_clr = 0;
    @(negedge clk);
    compare_all();
    handshake_checks();
    uart_model();
  endtask

  task automatic push(input logic [7:0] b);
    tx_wr = 1;
    tx_wdata = b;
    tick();
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit rd);
    uart_rx_done = 1;
    uart_dout = b;
    rx_rd = rd;
    tick();
  endtask

  task automatic drain_tx(input int max_cycles);
    bit done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      if (tx_q.size() == 0 && !uart_tx_busy && !uart_we) done = 1;
      else tick();
    end
    check("drain_done", done, 1);
  endtask

  initial begin
    rst = 0; enable = 0; tx_wr = 0; tx_wdata = 0; rx_rd = 0; ovf_clr = 0;
    uart_tx_busy = 0; uart_rx_done = 0; uart_dout = 0;
    force_busy = 0; wait_cnt = 0; busy_left = 0; busy_delay = 40; busy_len = 1000;
    pop_pending = 0; we_prev = 0;

    // Reset for two cycles
    repeat (2) tick();
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_we", uart_we, 0);

    // Two bytes through the slow UART handshake
    rst = 1; enable = 1;
    push(8'h55);
    push(8'hA3);
    drain_tx(5000);
    $display("tx handshake pair: tx_count=%0d", tx_count);

    // Overfill TX while the UART is held busy
    force_busy = 1;
    tick();
    for (int i = 0; i < 17; i++) push(8'($urandom));
    check("tx_full_after_17", tx_full, 1);
    check("tx_ovf_after_17", tx_ovf, 1);
    ovf_clr = 1;
    tick();
    check("tx_ovf_cleared", tx_ovf, 0);
    force_busy = 0; busy_delay = 3; busy_len = 5;
    drain_tx(2000);
    $display("tx overfill and drain: tx_count=%0d", tx_count);

    // RX basic ordering
    rx_byte(8'h41, 0);
    rx_byte(8'h42, 0);
    check("rx_head_41", rx_rdata, 8'h41);
    rx_rd = 1; tick();
    check("rx_head_42", rx_rdata, 8'h42);
    rx_rd = 1; tick();
    rx_rd = 1; tick();   // read while empty: ignored
    check("rx_empty_after_reads", rx_empty, 1);
    $display("rx ordering: rx_count=%0d", rx_count);

    // Fill RX, then receive and read in the same cycle while full
    for (int i = 0; i < 16; i++) rx_byte(8'($urandom), 0);
    rx_byte(8'hEE, 1);
    check("rx_count_15", rx_count, 15);
    check("rx_ovf_set", rx_ovf, 1);
    ovf_clr = 1; tick();
    for (int i = 0; i < 15; i++) begin rx_rd = 1; tick(); end
    $display("rx overflow: rx_count=%0d", rx_count);

    // Reset while a byte is being presented with three queued
    busy_delay = 40; busy_len = 6;
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 100 && !uart_we; i++) tick();
    check("we_presenting", uart_we, 1);
    repeat (5) tick();
    rst = 0; tick();
    rst = 1;
    check("rst_mid_tx_count", tx_count, 0);
    force_busy = 1; repeat (3) tick();
    force_busy = 0; repeat (3) tick();
    check("late_busy_tx_count", tx_count, 0);
    $display("reset mid-transfer: tx_count=%0d we=%0d", tx_count, uart_we);

    // Randomized mix
    for (int i = 0; i < 3000; i++) begin
      busy_delay = $urandom_range(1, 6);
      busy_len   = $urandom_range(1, 10);
      tx_wr = ($urandom_range(0, 99) < 35);
      tx_wdata = 8'($urandom);
      rx_rd = ($urandom_range(0, 99) < 30);
      uart_rx_done = ($urandom_range(0, 99) < 30);
      uart_dout = 8'($urandom);
      ovf_clr = ($urandom_range(0, 99) < 4);
      enable = pop_pending ? 1'b1 : ($urandom_range(0, 99) < 92);
      tick();
    end
    enable = 1;
    drain_tx(3000);
    $display("random mix: tx_count=%0d rx_count=%0d", tx_count, rx_count);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
